// File: rtl/vit_input_arbiter.sv
// Purpose: frame-level round-robin arbiter sharing the Viterbi decode path among NREQ requesters (stall watchdog: ARB_WATCHDOG_EN).
// Latency: grant registered one cycle after a valid is seen in IDLE; granted words forwarded combinationally (zero latency).
// Backpressure: busy_i drops the granted ready in the same cycle; the grant is held, never revoked by busy alone.
module vit_input_arbiter #(
  parameter  int NREQ      = 4,
  parameter  int MAX_WORDS = 256,
  parameter  int TIMEOUT   = 1024,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [16*NREQ-1:0]   req_data_i,
  input  logic [NREQ-1:0]      req_last_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 dvalid_o,
  output logic [15:0]          data_o,
  input  logic                 busy_i,
  output logic [IDW-1:0]       grant_id_o,
  output logic                 grant_active_o,
  output logic                 frame_start_o,
  output logic                 frame_err_o
);

  // Word counter only needs to reach MAX_WORDS-1: the MAX_WORDS-th accept ends the frame.
  localparam int CNTW = $clog2(MAX_WORDS);

  // Reject configurations the arbitration and counters are not sized for.
  if (NREQ < 2 || NREQ > 8 || MAX_WORDS < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("vit_input_arbiter: unsupported NREQ/MAX_WORDS/TIMEOUT");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  gid_nxt;
  logic [IDW-1:0]  gid_inc;
  logic [IDW-1:0]  sel_id;
  logic            sel_found;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic            g_valid;
  logic            g_last;
  logic            acc;
  logic            ovf;
  logic            stall_abort;

  assign g_valid = req_valid_i[grant_id_o];
  assign g_last  = req_last_i[grant_id_o];
  assign acc     = (state == GRANT) && g_valid && !busy_i;
  // Length overflow only counts when the word is not itself the last one: last wins.
  assign ovf     = acc && !g_last && (cnt == CNTW'(MAX_WORDS - 1));
  // Pointer after the current grant, wrapping at NREQ (which need not be a power of two).
  assign gid_inc = (grant_id_o == IDW'(NREQ - 1)) ? '0 : grant_id_o + 1'b1;

`ifdef ARB_WATCHDOG_EN
  localparam int TOW = $clog2(TIMEOUT + 1);
  logic [TOW-1:0] stall_cnt;

  // Abort on the TIMEOUT-th consecutive cycle with the granted valid low; busy stalls do not count.
  assign stall_abort = (state == GRANT) && !g_valid && (stall_cnt == TOW'(TIMEOUT - 1));

  // Stall counter: cleared outside GRANT and on every accept, counts empty-valid GRANT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE || acc || stall_abort) begin
      stall_cnt <= '0;
    end else if (!g_valid) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Without the watchdog a granted requester may hold the decoder indefinitely.
  assign stall_abort = 1'b0;
`endif

  // Round-robin pick: first requester with valid set at or after the pointer, wrapping upward.
  always_comb begin
    int k;
    sel_found = 1'b0;
    sel_id    = '0;
    k         = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!sel_found && req_valid_i[k]) begin
        sel_found = 1'b1;
        sel_id    = IDW'(k);
      end
    end
  end

  // State, grant, pointer and word-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id_o <= '0;
      ptr        <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      grant_id_o <= gid_nxt;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // Next-state: grant on any valid in IDLE; leave GRANT on last, overflow or stall abort.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id_o;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_nxt = GRANT;
          gid_nxt   = sel_id;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (acc) begin
          cnt_nxt = cnt + 1'b1;
          if (g_last || ovf) begin
            state_nxt = IDLE;
            ptr_nxt   = gid_inc;
          end
        end else if (stall_abort) begin
          state_nxt = IDLE;
          ptr_nxt   = gid_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Forwarding path: only the granted requester sees ready, and only while the decoder has room.
  always_comb begin
    req_ready_o = '0;
    data_o      = '0;
    if (state == GRANT) begin
      data_o = req_data_i[16*grant_id_o +: 16];
      if (!busy_i) begin
        req_ready_o[grant_id_o] = 1'b1;
      end
    end
  end

  assign dvalid_o       = acc;
  assign grant_active_o = (state == GRANT);
  assign frame_start_o  = acc && (cnt == '0);
  assign frame_err_o    = ovf || stall_abort;

endmodule

// File: tb/tb_vit_input_arbiter.sv
// Randomized scoreboard bench for vit_input_arbiter: a frame/word-level reference model
// predicts every forwarded word and the per-cycle handshake outputs; a monitor compares.
module tb_vit_input_arbiter;

  localparam int NREQ  = 4;
  localparam int MAXW  = 4;
  localparam int TMO   = 8;
  localparam int DEPTH = 4096;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid_i;
  logic [16*NREQ-1:0]  req_data_i;
  logic [NREQ-1:0]     req_last_i;
  logic [NREQ-1:0]     req_ready_o;
  logic                dvalid_o;
  logic [15:0]         data_o;
  logic                busy_i;
  logic [1:0]          grant_id_o;
  logic                grant_active_o;
  logic                frame_start_o;
  logic                frame_err_o;

  vit_input_arbiter #(.NREQ(NREQ), .MAX_WORDS(MAXW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .dvalid_o(dvalid_o), .data_o(data_o), .busy_i(busy_i),
    .grant_id_o(grant_id_o), .grant_active_o(grant_active_o),
    .frame_start_o(frame_start_o), .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  // Per-requester word streams
  typedef struct packed { logic [15:0] d; logic last; } word_t;
  word_t mem [NREQ][DEPTH];
  int    head [NREQ];
  int    tail [NREQ];

  // Scoreboard of expected forwarded words
  typedef struct { logic [15:0] d; int id; bit start; bit err; } exp_t;
  exp_t sbq [$];

  int n_cmp = 0;
  int n_err = 0;

  // Stimulus knobs
  int vprob = 100;
  int bprob = 0;
  bit force_busy = 1'b0;
  logic [NREQ-1:0] acc_bits = '0;

  // Reference model state (frame-level arbitration rules)
  bit              m_grant = 0;
  int              m_gid = 0;
  int              m_ptr = 0;
  int              m_cnt = 0;
  int              m_stall = 0;
  logic [NREQ-1:0] exp_ready;
  bit              exp_active, exp_dvalid, exp_err;
  int              exp_gid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input int k, input logic [15:0] d, input bit last);
    if (tail[k] < DEPTH) begin
      mem[k][tail[k]] = '{d: d, last: last};
      tail[k]++;
    end
  endtask

  task automatic push_frame(input int k, input int len, input bit with_last);
    for (int i = 0; i < len; i++) push_word(k, 16'($urandom), with_last && (i == len - 1));
  endtask

  // Make every stream end with a last word so any open grant can finish.
  task automatic terminate_all();
    for (int k = 0; k < NREQ; k++)
      if (tail[k] > 0 && !mem[k][tail[k]-1].last) push_word(k, 16'($urandom), 1'b1);
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NREQ; k++) if (head[k] < tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain_wait(input int budget);
    bit ok;
    ok = 1'b0;
    terminate_all();
    for (int c = 0; c < budget && !ok; c++) begin
      @(posedge clk);
      ok = all_empty();
    end
    repeat (3) @(posedge clk);
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  // Reference model: evaluated mid-cycle on the inputs that the next rising edge will see.
  always @(negedge clk) begin : model
    exp_t e;
    bit   found;
    int   k;
    int   g;
    exp_ready  = '0;
    exp_active = 0;
    exp_dvalid = 0;
    exp_err    = 0;
    if (!rst_n) begin
      m_grant = 0; m_gid = 0; m_ptr = 0; m_cnt = 0; m_stall = 0;
      exp_gid = 0;
    end else begin
      exp_gid = m_gid;
      if (!m_grant) begin
        found = 0;
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (!found && req_valid_i[k]) begin
            found = 1; m_gid = k; m_grant = 1; m_cnt = 0; m_stall = 0;
          end
        end
      end else begin
        g = m_gid;
        exp_active = 1;
        if (!busy_i) exp_ready[g] = 1'b1;
        if (req_valid_i[g] && !busy_i) begin
          exp_dvalid = 1;
          e.d = req_data_i[16*g +: 16];
          e.id = g;
          e.start = (m_cnt == 0);
          e.err = 0;
          m_cnt++;
          m_stall = 0;
          if (req_last_i[g]) begin
            m_grant = 0; m_ptr = (g + 1) % NREQ;
          end else if (m_cnt == MAXW) begin
            e.err = 1; exp_err = 1; m_grant = 0; m_ptr = (g + 1) % NREQ;
          end
          sbq.push_back(e);
        end else begin
`ifdef ARB_WATCHDOG_EN
          if (!req_valid_i[g]) begin
            m_stall++;
            if (m_stall == TMO) begin
              exp_err = 1; m_grant = 0; m_ptr = (g + 1) % NREQ;
            end
          end
`endif
        end
      end
    end
  end

  // Monitor: per-cycle handshake checks and scoreboard pops on every decoder strobe.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      chk("ready", 32'(req_ready_o), 32'(exp_ready));
      chk("grant_active", 32'(grant_active_o), 32'(exp_active));
      chk("grant_id", 32'(grant_id_o), 32'(exp_gid));
      chk("dvalid", 32'(dvalid_o), 32'(exp_dvalid));
      chk("frame_err", 32'(frame_err_o), 32'(exp_err));
      if (!exp_active) chk("data_idle", 32'(data_o), 32'd0);
      if (dvalid_o) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_word", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("word_data", 32'(data_o), 32'(e.d));
          chk("word_id", 32'(grant_id_o), 32'(e.id));
          chk("frame_start", 32'(frame_start_o), 32'(e.start));
          chk("word_err", 32'(frame_err_o), 32'(e.err));
        end
      end else begin
        chk("frame_start_idle", 32'(frame_start_o), 32'd0);
      end
      acc_bits = req_valid_i & req_ready_o;
    end
  end

  // Driver: retire accepted words, then present the next front word of each stream.
  initial begin : driver
    req_valid_i = '0; req_data_i = '0; req_last_i = '0; busy_i = 1'b0;
    for (int k = 0; k < NREQ; k++) begin head[k] = 0; tail[k] = 0; end
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (acc_bits[k] && head[k] < tail[k]) head[k]++;
        if (head[k] < tail[k]) begin
          req_valid_i[k] = ($urandom_range(99) < vprob);
          req_data_i[16*k +: 16] = mem[k][head[k]].d;
          req_last_i[k] = mem[k][head[k]].last;
        end else begin
          req_valid_i[k] = 1'b0;
          req_data_i[16*k +: 16] = 16'($urandom);
          req_last_i[k] = 1'($urandom);
        end
      end
      acc_bits = '0;
      busy_i = force_busy || ($urandom_range(99) < bprob);
    end
  end

  initial begin : global_timeout
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int budget;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single frame from requester 2
    push_word(2, 16'h1111, 0); push_word(2, 16'h2222, 0);
    push_word(2, 16'h3333, 0); push_word(2, 16'h4444, 1);
    drain_wait(50);

    // Round robin: everyone continuously valid with 2-word frames
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < NREQ; k++) push_frame(k, 2, 1);
    drain_wait(200);

    // Backpressure mid-frame
    push_frame(3, 4, 1);
    repeat (3) @(posedge clk);
    force_busy = 1'b1;
    repeat (5) @(posedge clk);
    force_busy = 1'b0;
    drain_wait(50);

    // Overflow: 6 words without last on requester 1, requester 2 pending
    push_frame(1, 6, 0);
    push_frame(2, 2, 1);
    drain_wait(100);

    // Stall: requester 0 sends one word then goes quiet
    push_frame(0, 1, 0);
    repeat (20) @(posedge clk);
    drain_wait(50);

    // Randomized traffic with busy and valid gaps
    vprob = 70; bprob = 25;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      if ($urandom_range(99) < 20) push_frame($urandom_range(NREQ-1), $urandom_range(6, 1), ($urandom_range(99) < 80));
    end

    // Reset in the middle of a frame
    budget = 0;
    while (!(m_grant && m_cnt > 0) && budget < 500) begin
      @(posedge clk);
      budget++;
      if (all_empty()) push_frame($urandom_range(NREQ-1), 4, 1);
    end
    chk("reset_setup_timeout", 32'(budget < 500), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if ($urandom_range(99) < 20) push_frame($urandom_range(NREQ-1), $urandom_range(6, 1), ($urandom_range(99) < 80));
    end

    vprob = 100; bprob = 0;
    drain_wait(4000);
    chk("sb_leftover", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vit_input_arbiter.md
# vit_input_arbiter

Frame-level round-robin arbiter that shares the single Viterbi decode path (FIFO → PISO → core → SIPO) among `NREQ` upstream requesters. It grants one requester at a time for a whole frame of 16-bit coded words, and forwards that requester's words onto the decoder input (`dvalid_i`/`data_i`), honouring the decoder's `busy_o` backpressure. It reports the granted channel ID for output routing, and it terminates oversized or, optionally, stalled frames.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_WORDS`, 256: maximum words per frame, ≥2.
- `TIMEOUT`, 1024: stall limit in cycles; used only with `ARB_WATCHDOG_EN`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  NREQ  per-requester word valid.
- `req_data_i`  in  16*NREQ  per-requester word; requester k uses bits [16k+15:16k].
- `req_last_i`  in  NREQ  marks the final word of a frame; qualified by valid.
- `req_ready_o`  out  NREQ  per-requester accept.
- `dvalid_o`  out  1  word strobe to the decoder `dvalid_i`.
- `data_o`  out  16  word to the decoder `data_i`.
- `busy_i`  in  1  decoder `busy_o` (input FIFO full).
- `grant_id_o`  out  clog2(NREQ)  currently granted requester.
- `grant_active_o`  out  1  high while in GRANT.
- `frame_start_o`  out  1  pulse on the first accepted word of a frame.
- `frame_err_o`  out  1  pulse when a frame is force-terminated.

## Operation
- FSM states: IDLE and GRANT. Reset state is IDLE.
- Reset values: `grant_id_o`=0, round-robin pointer=0, word count=0, all outputs 0.
- IDLE: when any `req_valid_i` bit is high, select the first requester with valid set at or after the pointer, scanning upward with wrap. Register the selection into `grant_id_o` and go to GRANT. If no valid bit is high, stay in IDLE.
- Accept and forward rules:
  - `req_ready_o[g]` = (state==GRANT) & (g==`grant_id_o`) & !`busy_i`. All other ready bits are 0.
  - An accept occurs when the granted requester's valid and ready are both high.
  - `dvalid_o` is high exactly on an accept. `data_o` is the granted requester's word (combinational mux). `data_o` is 0 when not in GRANT.
- Word counter:
  - Reset to 0 on entry to GRANT.
  - Increments on each accept.
  - `frame_start_o` pulses on an accept while the count is 0.
- Leaving GRANT:
  - Normal end: an accept with `req_last_i[g]`=1 returns to IDLE. The pointer is set to g+1 mod NREQ.
  - Length overflow: the `MAX_WORDS`-th accept without last returns to IDLE. That word is still forwarded. `frame_err_o` pulses on the same cycle and the pointer advances.
  - If both conditions hold on the same accept, last wins and `frame_err_o` stays 0.
- Backpressure: while `busy_i`=1, no accept occurs and the state is held. A grant is never revoked by `busy_i` alone.
- Asynchronous reset mid-frame returns to IDLE immediately. The partial frame already written to the decoder is not recalled.

## Timing
- Arbitration latency: requester valid seen in IDLE at cycle N → `grant_active_o`=1 and the requester's ready high (if not busy) at cycle N+1.
- Forwarding path is combinational, zero latency: `dvalid_o` and `data_o` are valid in the same cycle as the accept.
- Between frames there is exactly one IDLE cycle, so the maximum decoder input rate is L/(L+1) for a frame of L words.
- `busy_i` is sampled combinationally, so a full decoder FIFO blocks the accept in that same cycle.

## Configuration
- Macro: `ARB_WATCHDOG_EN`.
- Defined:
  - A stall counter resets on every accept and on GRANT entry. It increments each GRANT cycle in which the granted requester's valid is 0. It does not count busy-stalled cycles.
  - When the counter reaches `TIMEOUT`, the frame is aborted: go to IDLE, pulse `frame_err_o`, and advance the pointer.
- Not defined: no stall counter exists, and a granted requester may hold the decoder indefinitely.

## Test plan
- **Single frame:** requester 2 sends 4 words 0x1111..0x4444, last on the 4th, with `busy_i`=0. Expect `grant_id_o`=2 one cycle after valid, 4 `dvalid_o` strobes with identical data, `frame_start_o` on word 1, and a return to IDLE.
- **Round robin:** all 4 requesters continuously valid with 2-word frames. Expect grant order 0,1,2,3,0 with one idle cycle between frames.
- **Backpressure:** `busy_i`=1 for 5 cycles mid-frame. Expect `req_ready_o` and `dvalid_o` at 0 throughout, no word lost or duplicated, and the grant held.
- **Overflow:** `MAX_WORDS`=4 and requester 1 sends 6 words with no last. Expect 4 words forwarded, `frame_err_o` on the 4th, and the next grant to a different requester if one is pending.
- **Watchdog:** with `ARB_WATCHDOG_EN` and `TIMEOUT`=8, requester 0 drops valid after 1 word. Expect `frame_err_o` 8 cycles later and a return to IDLE. Without the macro, expect the grant to be held.
- **Reset mid-frame:** assert `rst_n`=0 during GRANT. Expect all outputs 0 immediately and the pointer at 0 after release.
